// File: rtl/vdp_port.sv
// CPU-side port of a TMS9918-style VDP: decodes the 0x98/0x99 protocol, owns R0-R7,
// the VRAM address counter, the read-ahead buffer and the frame-interrupt flag.
module vdp_port #(
  parameter int ADDR_W = 14,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              io_wr,
  input  logic              io_rd,
  input  logic              io_port,
  input  logic [7:0]        io_din,
  output logic [7:0]        io_dout,
  input  logic              vblank,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_dout,
  output logic              vram_wr,
  output logic              vram_rd,
  input  logic [7:0]        vram_din,
  output logic [1:0]        mode,
  output logic [13:0]       name_table_addr,
  output logic [13:0]       color_table_addr,
  output logic [13:0]       font_addr,
  output logic [13:0]       sprite_attr_addr,
  output logic [13:0]       sprite_pattern_table_addr,
  output logic [3:0]        text_color,
  output logic [3:0]        back_color,
  output logic              video_on,
  output logic              n_int,
  output logic              busy
);

  localparam int RI_W = $clog2(NREGS);

  typedef enum logic [1:0] {IDLE, WRITE, READ_REQ, READ_CAP} state_t;

  state_t            state;
  logic [7:0]        regs [NREGS];
  logic [ADDR_W-1:0] addr;
  logic [7:0]        rbuf;
  logic [7:0]        first_byte;
  logic [7:0]        wdata;
  logic              toggle;
  logic              flag;
  logic              regs_unused;

  // Strobes are only honoured in IDLE; anything arriving while busy is simply dropped.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= IDLE;
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
      addr       <= '0;
      rbuf       <= 8'h00;
      first_byte <= 8'h00;
      wdata      <= 8'h00;
      toggle     <= 1'b0;
      flag       <= 1'b0;
      io_dout    <= 8'h00;
      vram_wr    <= 1'b0;
      vram_rd    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      vram_wr <= 1'b0;
      vram_rd <= 1'b0;
      // A frame-end pulse beats a simultaneous status read, so the flag is never lost.
      if (vblank)
        flag <= 1'b1;
      else if (state == IDLE && io_rd && !io_wr && io_port)
        flag <= 1'b0;

      case (state)
        IDLE: begin
          if (io_wr) begin
            if (io_port) begin
              if (!toggle) begin
                first_byte <= io_din;
                toggle     <= 1'b1;
              end else begin
                toggle <= 1'b0;
                if (io_din[7]) begin
                  regs[io_din[RI_W-1:0]] <= first_byte;
                end else begin
                  addr <= ADDR_W'({io_din[5:0], first_byte});
                  if (!io_din[6]) begin
                    state   <= READ_REQ;
                    vram_rd <= 1'b1;
                    busy    <= 1'b1;
                  end
                end
              end
            end else begin
              toggle  <= 1'b0;
              wdata   <= io_din;
              state   <= WRITE;
              vram_wr <= 1'b1;
              busy    <= 1'b1;
            end
          end else if (io_rd) begin
            toggle <= 1'b0;
            if (io_port) begin
              io_dout <= {flag, 7'b0};
            end else begin
              io_dout <= rbuf;
              state   <= READ_REQ;
              vram_rd <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end
        WRITE: begin
          rbuf  <= wdata;
          addr  <= addr + ADDR_W'(1);
          state <= IDLE;
          busy  <= 1'b0;
        end
        READ_REQ: begin
          state <= READ_CAP;
        end
        READ_CAP: begin
          rbuf  <= vram_din;
          addr  <= addr + ADDR_W'(1);
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign vram_addr = addr;
  assign vram_dout = wdata;

  always_comb begin
    mode = 2'd1;
    if (regs[1][4])
      mode = 2'd0;
    else if (regs[1][3])
      mode = 2'd3;
    else if (regs[0][1])
      mode = 2'd2;
  end

  assign name_table_addr           = {regs[2][3:0], 10'b0};
  assign color_table_addr          = {regs[3], 6'b0};
  assign font_addr                 = {regs[4][2:0], 11'b0};
  assign sprite_attr_addr          = {regs[5][6:0], 7'b0};
  assign sprite_pattern_table_addr = {regs[6][2:0], 11'b0};
  assign text_color                = regs[7][7:4];
  assign back_color                = regs[7][3:0];
  assign video_on                  = regs[1][6];
  assign n_int                     = !(flag && regs[1][5]);

  assign regs_unused = ^{regs[0][7:2], regs[0][0], regs[1][7], regs[1][2:0],
                         regs[2][7:4], regs[4][7:3], regs[5][7], regs[6][7:3]};

endmodule

// File: doc/vdp_port.md
Name: vdp_port

Overview:
- CPU-side I/O front end of the TMS9918-style VDP; the writer/register end of the interface the video generator reads.
- Decodes the MSX data and control port protocol and drives VRAM port A writes and read-ahead fetches.
- Holds VDP registers R0–R7 and decodes them into the mode, table-base, colour and enable signals the video generator consumes.
- Holds the status register and the frame-interrupt flag, and drives n_int.

Parameters:
ADDR_W, 14, VRAM address width
NREGS, 8, number of VDP control registers (index = low 3 bits)

Ports:
clk  input  1  system clock
n_reset  input  1  reset, asynchronous, active-low
io_wr  input  1  one-cycle CPU write strobe, already synchronous to clk
io_rd  input  1  one-cycle CPU read strobe, already synchronous to clk
io_port  input  1  0 = data port (0x98), 1 = control port (0x99)
io_din  input  8  CPU write data
io_dout  output  8  CPU read data, registered
vblank  input  1  one-cycle frame-end pulse from the video timing
vram_addr  output  14  VRAM address
vram_dout  output  8  VRAM write data
vram_wr  output  1  VRAM write enable, one cycle
vram_rd  output  1  VRAM read enable, one cycle; data valid on vram_din the next cycle
vram_din  input  8  VRAM read data
mode  output  2  0 text (M1), 1 graphics I, 2 graphics II (M3), 3 multicolor (M2)
name_table_addr  output  14  {R2[3:0],10'b0}
color_table_addr  output  14  {R3,6'b0}
font_addr  output  14  {R4[2:0],11'b0}
sprite_attr_addr  output  14  {R5[6:0],7'b0}
sprite_pattern_table_addr  output  14  {R6[2:0],11'b0}
text_color  output  4  R7[7:4]
back_color  output  4  R7[3:0]
video_on  output  1  R1[6]
n_int  output  1  !(F & R1[5])
busy  output  1  high when the FSM is not IDLE

Behaviour:
- Reset (async, n_reset=0):
  - R0–R7, address counter, read buffer, first-byte latch, toggle flip-flop, F and io_dout all = 0.
  - vram_wr = vram_rd = 0; FSM in IDLE.
  - Resulting outputs: mode=1, video_on=0, n_int=1, busy=0.
  - Reset mid-operation aborts any pending write or fetch; nothing is issued after release.
- Strobe acceptance:
  - Strobes are sampled only in IDLE; strobes arriving while busy=1 are dropped with no state change.
  - io_wr and io_rd in the same cycle: io_wr wins, io_rd is ignored.
- Control write, toggle=0: latch io_din; toggle <= 1.
- Control write, toggle=1 (toggle <= 0 in all cases):
  - io_din[7]=1: R[io_din[2:0]] <= latch.
  - io_din[7:6]=01: addr <= {io_din[5:0], latch}; write setup, no VRAM access.
  - io_din[7:6]=00: addr <= {io_din[5:0], latch}; start prefetch (READ_REQ).
- Data write at cycle t:
  - toggle <= 0.
  - Cycle t+1 (state WRITE): vram_wr=1, vram_addr=addr, vram_dout=io_din; read buffer <= io_din; addr <= addr+1.
  - Returns to IDLE at t+2.
- Data read at cycle t:
  - io_dout <= read buffer (valid from t+1); toggle <= 0; then prefetch.
- Prefetch:
  - READ_REQ: vram_rd=1, vram_addr=addr.
  - READ_CAP: read buffer <= vram_din; addr <= addr+1.
  - Then IDLE. busy is high for 2 cycles.
- Control read at t:
  - io_dout <= {F, 7'b0} at t+1; F <= 0; toggle <= 0.
  - If vblank coincides with a status read, F remains 1 and the returned value shows the pre-read F.
- vblank pulse: F <= 1.
- Address counter is 14-bit and wraps 0x3FFF -> 0x0000.
- Mode decode:
  - R1[4] -> 0.
  - else R1[3] -> 3.
  - else R0[1] -> 2.
  - else 1.
- io_dout holds its value between reads. Decoded outputs are combinational from the registers.
- FSM states: IDLE, WRITE, READ_REQ, READ_CAP. Every non-IDLE state lasts exactly one cycle.

Test Plan:
- Register write: control writes 0x0F, 0x87 -> R7=0x0F, text_color=0, back_color=0xF; then control writes 0x06, 0x82 -> name_table_addr=0x1800.
- VRAM write: control 0x00, 0x40; data writes 0xAA, 0x55 -> vram_wr pulses at 0x0000 (0xAA) and 0x0001 (0x55), busy high 1 cycle each; a strobe during busy produces no write.
- Read-ahead: VRAM model 0x0100=0x12, 0x0101=0x34; control 0x00, 0x01 -> vram_rd at 0x0100; data reads return 0x12 then 0x34; next fetch at 0x0102.
- Interrupt: R1=0x60 (write 0x60, 0x81) -> video_on=1; vblank -> n_int=0; status read returns 0x80, n_int=1; second status read returns 0x00; vblank coinciding with a read keeps F=1.
- Toggle reset and wrap: control 0x12, status read, control 0x34, 0x82 -> R2=0x34; address 0x3FFF plus two data writes -> addresses 0x3FFF, then 0x0000.
- Reset mid-fetch: assert n_reset during READ_REQ -> no READ_CAP and no capture; mode=1, n_int=1, busy=0 after release.
